id_hazard_controller: RTL and testbench

ID_HAZARD_CONTROLLER -- requirements
Module: id_hazard_controller

---
 rtl/id_hazard_controller.sv | 70 +++++++
 tb/tb_id_hazard_controller.sv | 124 ++++++++++++
 2 files changed

// File: rtl/id_hazard_controller.sv
// id_hazard_controller: load-use interlock, memory freeze and flush control for the decode stage
module id_hazard_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rf1,
  input  logic [4:0]  id_rf2,
  input  logic        id_rf1_used,
  input  logic        id_rf2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        flush,
  input  logic        mem_busy,
  output logic        stall_if,
  output logic        bubble_ex,
  output logic        issue,
  output logic [1:0]  state,
  output logic [31:0] pending_mask,
  output logic [15:0] stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'b00, LU_STALL = 2'b01, MEM_WAIT = 2'b10} state_t;
  state_t st;
  logic       ex_v, ex_w, ex_ld, mem_v, mem_w, mem_ld, wb_v, wb_w, wb_ld;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       hazard;
  // A load in EX whose result decode needs cannot be forwarded in time; XZR never conflicts
  always_comb begin
    hazard = id_valid & ex_v & ex_ld & ex_w & (ex_rd != 5'd31) &
             ((id_rf1_used & (id_rf1 == ex_rd)) | (id_rf2_used & (id_rf2 == ex_rd)));
    stall_if  = mem_busy | hazard;
    bubble_ex = hazard & ~mem_busy & ~flush;
    issue     = id_valid & ~stall_if & ~flush;
    state     = st;
  end
  // Registers with in-flight writes; bit 31 is XZR and is never pending
  always_comb begin
    pending_mask = ((ex_v & ex_w) ? (32'd1 << ex_rd) : 32'd0) |
                   ((mem_v & mem_w) ? (32'd1 << mem_rd) : 32'd0) |
                   ((wb_v & wb_w) ? (32'd1 << wb_rd) : 32'd0);
    pending_mask[31] = 1'b0;
  end
  // In-flight slots shift every cycle unless memory freezes the whole pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ex_v, ex_w, ex_ld, mem_v, mem_w, mem_ld, wb_v, wb_w, wb_ld} <= '0;
      {ex_rd, mem_rd, wb_rd} <= {3{5'd31}};
    end else if (!mem_busy) begin
      {wb_v, wb_rd, wb_w, wb_ld} <= {mem_v, mem_rd, mem_w, mem_ld};
      {mem_v, mem_rd, mem_w, mem_ld} <= {ex_v & ~flush, ex_rd, ex_w, ex_ld};
      if (issue) {ex_v, ex_rd, ex_w, ex_ld} <= {1'b1, id_rd, id_regwrite, id_memread};
      else ex_v <= 1'b0;
    end
  end
  // Controller state: one-cycle load-use stall, or wait while memory is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= RUN;
    else case (st)
      RUN:      st <= mem_busy ? MEM_WAIT : (hazard & ~flush) ? LU_STALL : RUN;
      LU_STALL: st <= mem_busy ? MEM_WAIT : RUN;
      MEM_WAIT: st <= mem_busy ? MEM_WAIT : RUN;
      default:  st <= RUN;
    endcase
  end
  // Saturating count of cycles in which fetch was held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (stall_if && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_id_hazard_controller.sv
// tb_id_hazard_controller: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_id_hazard_controller;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid = 0, id_rf1_used = 0, id_rf2_used = 0, id_regwrite = 0, id_memread = 0;
  logic [4:0]  id_rf1 = 0, id_rf2 = 0, id_rd = 0;
  logic        flush = 0, mem_busy = 0;
  logic        stall_if, bubble_ex, issue;
  logic [1:0]  state;
  logic [31:0] pending_mask;
  logic [15:0] stall_cnt;
  int          errors = 0, checks = 0;

  typedef struct {
    string  nm;
    int     e_stall, e_bub, e_iss, e_st;
    longint e_pm;
    int     e_cnt;
  } exp_t;
  exp_t sb[$];

  id_hazard_controller dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rf1(id_rf1), .id_rf2(id_rf2),
    .id_rf1_used(id_rf1_used), .id_rf2_used(id_rf2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .mem_busy(mem_busy),
    .stall_if(stall_if), .bubble_ex(bubble_ex), .issue(issue), .state(state),
    .pending_mask(pending_mask), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(string nm, string f, longint act, longint exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, f, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.nm, "stall_if", longint'(stall_if), e.e_stall);
      cmp(e.nm, "bubble_ex", longint'(bubble_ex), e.e_bub);
      cmp(e.nm, "issue", longint'(issue), e.e_iss);
      cmp(e.nm, "state", longint'(state), e.e_st);
      cmp(e.nm, "pending_mask", longint'(pending_mask), e.e_pm);
      cmp(e.nm, "stall_cnt", longint'(stall_cnt), e.e_cnt);
    end
  end

  task automatic vec(string nm, logic v, logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                     logic [4:0] rd, logic rw, logic ld, logic fl, logic mb,
                     int es, int eb, int ei, int est, longint epm, int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_rf1 = r1; id_rf1_used = u1; id_rf2 = r2; id_rf2_used = u2;
    id_rd = rd; id_regwrite = rw; id_memread = ld; flush = fl; mem_busy = mb;
    e = '{nm, es, eb, ei, est, epm, ecnt};
    sb.push_back(e);
  endtask

  task automatic idle(string nm, int est, longint epm, int ecnt);
    vec(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, est, epm, ecnt);
  endtask

  initial begin
    exp_t e;
    vec("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // load-use: LDUR X3 then consumer of X3
    vec("lu_load", 1, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    vec("lu_stall", 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 1, 0, 0, 32'h8, 0);
    vec("lu_issue", 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 1, 32'h8, 1);
    idle("lu_after", 0, 32'h18, 1);
    idle("lu_drain1", 0, 32'h10, 1);
    idle("lu_drain2", 0, 32'h10, 1);
    idle("lu_drain3", 0, 0, 1);
    // XZR and unused source never stall
    vec("xzr_load", 1, 1, 1, 0, 0, 31, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    vec("xzr_use", 1, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    vec("unused_load", 1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    vec("unused_use", 1, 7, 1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 1, 0, 32'h20, 1);
    // memory freeze with EX/MEM/WB occupied
    vec("freeze1", 1, 1, 1, 0, 0, 8, 1, 0, 0, 1, 1, 0, 0, 0, 32'h60, 1);
    vec("freeze2", 1, 1, 1, 0, 0, 8, 1, 0, 0, 1, 1, 0, 0, 2, 32'h60, 2);
    vec("freeze3", 1, 1, 1, 0, 0, 8, 1, 0, 0, 1, 1, 0, 0, 2, 32'h60, 3);
    idle("freeze_end", 2, 32'h60, 4);
    idle("freeze_run", 0, 32'h60, 4);
    idle("freeze_drain1", 0, 32'h40, 4);
    idle("freeze_drain2", 0, 0, 4);
    // flush wins over a simultaneous hazard
    vec("fl_load", 1, 1, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 1, 0, 0, 4);
    vec("fl_hazard", 1, 9, 1, 0, 0, 10, 1, 0, 1, 0, 1, 0, 0, 0, 32'h200, 4);
    idle("fl_after", 0, 0, 5);
    // saturation, then asynchronous reset in MEM_WAIT
    vec("sat_load", 1, 1, 1, 0, 0, 12, 1, 1, 0, 0, 0, 0, 1, 0, 0, 5);
    vec("sat_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h1000, 5);
    for (int i = 0; i < 65540; i++) @(posedge clk);
    vec("sat_top", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 32'h1000, 16'hFFFF);
    @(posedge clk);
    #1;
    rst_n = 1'b0; mem_busy = 1'b0; id_valid = 1'b0;
    #1;
    e = '{"mid_reset", 0, 0, 0, 0, 0, 0};
    sb.push_back(e);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle("post_reset", 0, 0, 0);
    idle("post_reset2", 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
